// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: start/busy/done handshake and result bus of the binary-to-BCD converter
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
);
  logic                  iStart;
  logic [WIDTH-1:0]      ivBin;
  logic                  oBusy;
  logic                  oDone;
  logic [4*DIGITS-1:0]   ovBCD;
  logic                  oOverflow;
  modport master (output iStart, ivBin, input oBusy, oDone, ovBCD, oOverflow);
  modport slave  (input iStart, ivBin, output oBusy, oDone, ovBCD, oOverflow);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: shift-and-add-3 binary-to-BCD converter, one bit per clock; define BCD_SATURATE_EN to saturate out-of-range values to all 9s
module bin_to_bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input logic            iclk,
  input logic            iReset,
  bin_to_bcd_seq_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t          state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]   scr_q, scr_d, adj, bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d, ovf_out_q, ovf_out_d, over;
`ifdef BCD_SATURATE_EN
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);
  assign over = 32'(bus.ivBin) > MAX_VAL;
`else
  assign over = 1'b0;
`endif
  always_comb begin
    adj = '0;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k+:4] = scr_q[4*k+:4] >= 4'd5 ? scr_q[4*k+:4] + 4'd3 : scr_q[4*k+:4];
  end
  // the top bit of adj falls off on the shift, discarding the carry out of the top digit
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scr_d     = scr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    ovf_out_d = ovf_out_q;
    case (state_q)
      IDLE: if (bus.iStart) begin
        state_d = CONV;
        shift_d = bus.ivBin;
        scr_d   = '0;
        cnt_d   = CW'(WIDTH);
        ovf_d   = over;
      end
      CONV: begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        scr_d   = {adj[BW-2:0], shift_q[WIDTH-1]};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          bcd_d     = ovf_q ? {DIGITS{4'h9}} : scr_d;
          ovf_out_d = ovf_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge iclk) begin
    if (iReset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scr_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scr_q     <= scr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      ovf_out_q <= ovf_out_d;
    end
  end
  assign bus.oBusy     = state_q == CONV;
  assign bus.oDone     = state_q == DONE;
  assign bus.ovBCD     = bcd_q;
  assign bus.oOverflow = ovf_out_q;
endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that turns the spirometer's binary measurement into packed decimal digits for the display path. It sits directly upstream of the per-digit 7-segment decoders. Each 4-bit digit slice of `ovBCD` feeds one decoder's digit input, and the one-cycle `oDone` pulse drives the decoders' load enable. It uses a start/busy/done handshake so the measurement logic can fire a conversion whenever a new value is ready.

## Interface
- `WIDTH`, default 14: width of the binary input.
- `DIGITS`, default 4: number of BCD digits produced.
- `iclk`  in  1  clock; all logic on the rising edge.
- `iReset`  in  1  reset; synchronous, active-high.
- `iStart`  in  1  request a conversion of `ivBin`. Sampled only in IDLE.
- `ivBin`  in  WIDTH  binary value. Captured on the accepting edge and not needed afterwards.
- `oBusy`  out  1  high while a conversion is in progress.
- `oDone`  out  1  one-cycle pulse when `ovBCD` holds a new result.
- `ovBCD`  out  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k], and digit 0 is the units digit.
- `oOverflow`  out  1  high if the last captured value was greater than 10^DIGITS−1.

## Operation
- States are IDLE, CONV and DONE.
- **IDLE**, when `iStart`=1:
  - load the shift register with `ivBin`;
  - clear the BCD scratch register;
  - load the bit counter with WIDTH;
  - evaluate overflow and hold it in an internal flag;
  - go to CONV.
- **IDLE**, when `iStart`=0: stay in IDLE.
- **CONV**, every edge:
  - each scratch digit ≥5 gets +3;
  - shift {scratch, shift reg} left by one bit;
  - decrement the counter.
  - The step where the counter goes 1→0 goes to DONE.
- **CONV carry-out**: the carry out of the top digit is discarded, so the scratch result equals the value mod 10^DIGITS.
- **Entering DONE**: register the final scratch value into `ovBCD`, copy the overflow flag into `oOverflow`, and assert `oDone`.
- **DONE**: lasts exactly one cycle, then returns unconditionally to IDLE.
- `iStart` is ignored in CONV and DONE; no queueing.
- `ovBCD` and `oOverflow` are only written on entry to DONE. They hold the last result until the next DONE.
- `oBusy` is 1 in CONV and 0 in IDLE and DONE.
- **Reset** (in any state, including mid-conversion): go to IDLE, and clear every output and internal register. The interrupted conversion produces no `oDone`.

## Timing
- Reset values: `oBusy`=0, `oDone`=0, `ovBCD`=0, `oOverflow`=0.
- Accepting edge T (IDLE with `iStart`=1): `oBusy` rises after T.
- CONV covers edges T+1 … T+WIDTH; the edge T+WIDTH enters DONE.
- After edge T+WIDTH: `ovBCD` and `oOverflow` are valid and `oDone`=1. `oBusy` is 0 from that edge on.
- At edge T+WIDTH+1: `oDone` returns to 0 and the state is IDLE.
- The earliest next accepting edge is T+WIDTH+2.
- Latency from start to `oDone`: WIDTH+1 cycles. With the defaults that is 15 cycles, and the throughput is one conversion per 16 cycles.
- `ovBCD` is stable while `oDone` is high, so the downstream decoders capture it on the edge after the pulse.

## Configuration
- **`BCD_SATURATE_EN` defined**: if the captured value is greater than 10^DIGITS−1, `ovBCD` is all 9s (0x9999 for 4 digits) and `oOverflow`=1 on DONE.
  - In-range values give the exact result with `oOverflow`=0.
- **`BCD_SATURATE_EN` not defined**:
  - no compare logic is built;
  - `oOverflow` is tied to 0;
  - `ovBCD` is the value mod 10^DIGITS.

## Test plan
- Reset, then `ivBin`=1234 with a one-cycle `iStart` → `oBusy` high for 14 cycles. On the 15th edge `ovBCD`=0x1234 with a single `oDone` pulse and `oOverflow`=0.
- Boundary values converted back-to-back, each started on the first cycle the design is back in IDLE:
  - 0 → 0x0000
  - 9 → 0x0009
  - 10 → 0x0010
  - 9999 → 0x9999
  - Each must appear exactly 15 cycles after its start.
- `ivBin`=12345:
  - with `BCD_SATURATE_EN` → 0x9999, `oOverflow`=1;
  - without it → 0x2345, `oOverflow`=0.
  - A following start with 42 → 0x0042 and `oOverflow`=0.
- Convert 500, then pulse `iStart` with `ivBin`=777 at cycles 3 and 14 of the conversion and on the DONE cycle → result 0x0500, a single `oDone`, and no second conversion starts.
- Start a conversion of 8888, then assert `iReset` at cycle 7 → every output is 0 on the next edge and no `oDone` follows. A later conversion of 56 → 0x0056.
